// File: rtl/branch_resolve_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl_if
// Brief    : Pipeline-side bus between the branch resolution controller and the core.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic             stall_in;
    logic             brun_en;
    logic             breq_flag;
    logic             brlt_flag;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             illegal_branch;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, stall_in, breq_flag, brlt_flag,
        input  pred_taken, brun_en, redirect_valid, redirect_pc, flush,
               illegal_branch, br_count, mispred_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, stall_in, breq_flag, brlt_flag,
        output pred_taken, brun_en, redirect_valid, redirect_pc, flush,
               illegal_branch, br_count, mispred_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl
// Brief    : Resolves EX-stage conditional branches, trains a 2-bit BHT and
//            sequences redirect/flush on mispredicts.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input wire logic             clk,
    input wire logic             rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int         c_bht_depth = 1 << BHT_IDX_W;
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_FLUSH     = 2'd1;
    localparam logic [1:0] c_DRAIN     = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [1:0]           r_bht [c_bht_depth];
    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;
    logic                 r_flush;
    logic                 r_illegal;
    logic [CNT_W-1:0]     r_br_count;
    logic [CNT_W-1:0]     r_mispred_count;
    logic [BHT_IDX_W-1:0] w_if_idx;
    logic [BHT_IDX_W-1:0] w_ex_idx;
    logic                 w_resolve;
    logic                 w_illegal_f3;
    logic                 w_legal;
    logic                 w_taken;
    logic                 w_mispred;
    logic [31:0]          w_correct_pc;

    assign w_if_idx       = bus.if_pc[BHT_IDX_W+1:2];
    assign w_ex_idx       = bus.ex_pc[BHT_IDX_W+1:2];
    assign bus.pred_taken = r_bht[w_if_idx][1];
    assign bus.brun_en    = bus.ex_funct3[1];

    // Only IDLE accepts EX contents; FLUSH/DRAIN cycles carry wrong-path instructions.
    assign w_resolve    = bus.ex_valid & bus.ex_is_branch & ~bus.stall_in & (r_state == c_IDLE);
    assign w_illegal_f3 = (bus.ex_funct3[2:1] == 2'b01);
    assign w_legal      = w_resolve & ~w_illegal_f3;

    always_comb begin
        w_taken = 1'b0;
        case (bus.ex_funct3)
            3'b000:         w_taken = bus.breq_flag;
            3'b001:         w_taken = ~bus.breq_flag;
            3'b100, 3'b110: w_taken = bus.brlt_flag;
            3'b101, 3'b111: w_taken = ~bus.brlt_flag;
            default:        w_taken = 1'b0;
        endcase
    end

    assign w_mispred    = w_legal & (w_taken != bus.ex_pred_taken);
    assign w_correct_pc = w_taken ? bus.ex_target : (bus.ex_pc + 32'd4);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_mispred) w_state_nxt = c_FLUSH;
            c_FLUSH: w_state_nxt = c_DRAIN;
            c_DRAIN: w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_illegal        <= 1'b0;
            r_br_count       <= '0;
            r_mispred_count  <= '0;
            for (int i = 0; i < c_bht_depth; i++) r_bht[i] <= 2'b01;
        end else begin
            r_redirect_valid <= (w_state_nxt == c_FLUSH);
            r_flush          <= (w_state_nxt != c_IDLE);
            r_illegal        <= w_resolve & w_illegal_f3;
            if (w_mispred) r_redirect_pc <= w_correct_pc;
            if (w_legal) begin
                if (w_taken) begin
                    if (r_bht[w_ex_idx] != 2'b11) r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
                end else begin
                    if (r_bht[w_ex_idx] != 2'b00) r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
                end
                if (r_br_count != '1) r_br_count <= r_br_count + CNT_W'(1);
            end
            if (w_mispred && (r_mispred_count != '1)) r_mispred_count <= r_mispred_count + CNT_W'(1);
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = r_flush;
    assign bus.illegal_branch = r_illegal;
    assign bus.br_count       = r_br_count;
    assign bus.mispred_count  = r_mispred_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_ctrl
// Brief    : Scoreboard bench: operand-level reference model feeds an expected
//            queue, a negedge monitor compares every presented cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;
    localparam int          BHT_IDX_W = 4;
    localparam int          CNT_W     = 16;
    localparam int unsigned c_cnt_max = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.CNT_W(CNT_W)) bus ();
    branch_resolve_ctrl #(.BHT_IDX_W(BHT_IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          pred_taken;
        bit          brun_en;
        bit          redirect_valid;
        bit [31:0]   redirect_pc;
        bit          flush;
        bit          illegal;
        int unsigned br;
        int unsigned mis;
    } exp_t;
    exp_t exp_q[$];

    int          m_bht [1 << BHT_IDX_W];
    int          m_squash;
    bit          m_rv, m_flush, m_ill, m_known;
    bit [31:0]   m_rpc;
    int unsigned m_br, m_mis;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic bit model_pred(input bit [31:0] pc);
        return m_bht[pc[BHT_IDX_W+1:2]] >= 2;
    endfunction

    // One pipeline cycle: drive inputs, record what the DUT must show this cycle, then advance the model.
    task automatic step(input bit r, input bit v, input bit isb, input bit [2:0] f3,
                        input bit [31:0] pc, input bit [31:0] tgt, input bit pt, input bit st,
                        input bit [31:0] a, input bit [31:0] b, input bit [31:0] ipc);
        exp_t e;
        bit   unsgn, taken, illegal;
        int   idx;
        @(posedge clk);
        #1;
        unsgn = f3[1];
        rst                = r;
        bus.ex_valid       = v;
        bus.ex_is_branch   = isb;
        bus.ex_funct3      = f3;
        bus.ex_pc          = pc;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.stall_in       = st;
        bus.if_pc          = ipc;
        bus.breq_flag      = (a == b);
        bus.brlt_flag      = unsgn ? (a < b) : ($signed(a) < $signed(b));
        if (m_known) begin
            e.pred_taken     = model_pred(ipc);
            e.brun_en        = unsgn;
            e.redirect_valid = m_rv;
            e.redirect_pc    = m_rpc;
            e.flush          = m_flush;
            e.illegal        = m_ill;
            e.br             = m_br;
            e.mis            = m_mis;
            exp_q.push_back(e);
        end
        if (r) begin
            foreach (m_bht[i]) m_bht[i] = 1;
            m_squash = 0; m_rv = 0; m_flush = 0; m_ill = 0; m_rpc = 0;
            m_br = 0; m_mis = 0; m_known = 1;
        end else begin
            m_rv = 0; m_ill = 0;
            if (m_squash > 0) begin
                m_squash--;
            end else if (v && isb && !st) begin
                taken = 0; illegal = 0;
                case (f3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = ($signed(a) <  $signed(b));
                    3'b101:  taken = ($signed(a) >= $signed(b));
                    3'b110:  taken = (a <  b);
                    3'b111:  taken = (a >= b);
                    default: illegal = 1;
                endcase
                if (illegal) begin
                    m_ill = 1;
                end else begin
                    idx = int'(pc[BHT_IDX_W+1:2]);
                    m_bht[idx] = taken ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                                       : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
                    if (m_br < c_cnt_max) m_br++;
                    if (taken != pt) begin
                        if (m_mis < c_cnt_max) m_mis++;
                        m_rv     = 1;
                        m_rpc    = taken ? tgt : pc + 32'd4;
                        m_squash = 2;
                    end
                end
            end
            m_flush = (m_squash > 0);
        end
    endtask

    task automatic idle(input int n, input bit [31:0] ipc);
        for (int k = 0; k < n; k++) step(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, ipc);
    endtask

    function automatic bit [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return $urandom;
            default: return 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pred_taken",     32'(bus.pred_taken),     32'(e.pred_taken));
                chk("brun_en",        32'(bus.brun_en),        32'(e.brun_en));
                chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.redirect_valid));
                chk("redirect_pc",    bus.redirect_pc,         e.redirect_pc);
                chk("flush",          32'(bus.flush),          32'(e.flush));
                chk("illegal_branch", 32'(bus.illegal_branch), 32'(e.illegal));
                chk("br_count",       32'(bus.br_count),       e.br);
                chk("mispred_count",  32'(bus.mispred_count),  e.mis);
            end
        end
    end

    initial begin : driver
        bit [31:0] a, b, pc, ipc;
        rst = 1'b1;
        bus.if_pc = 0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_funct3 = 0;
        bus.ex_pc = 0; bus.ex_target = 0; bus.ex_pred_taken = 0; bus.stall_in = 0;
        bus.breq_flag = 0; bus.brlt_flag = 0;
        m_known = 0;
        step(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h100);
        step(1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 32'h100);

        // BEQ taken against a not-taken prediction, then observe BHT[0] through if_pc
        idle(1, 32'h100);
        step(0, 1, 1, 3'b000, 32'h100, 32'h200, 0, 0, 5, 5, 32'h100);
        idle(3, 32'h100);

        // signed BLT predicted taken, actually not taken
        step(0, 1, 1, 3'b100, 32'h40, 32'h80, 1, 0, 5, 3, 32'h40);
        idle(3, 32'h40);

        // repeated taken branches at one index drive the counter to saturation
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 3'b001, 32'h48, 32'h300, model_pred(32'h48), 0, 1, 2, 32'h48);
            idle(3, 32'h48);
        end

        // unsupported funct3 and comparator-select decode
        step(0, 1, 1, 3'b010, 32'h10, 32'h20, 0, 0, 1, 1, 32'h10);
        step(0, 1, 1, 3'b011, 32'h10, 32'h20, 1, 0, 1, 2, 32'h10);
        step(0, 1, 1, 3'b110, 32'h14, 32'h20, 1, 0, 1, 2, 32'h14);
        step(0, 1, 1, 3'b100, 32'h18, 32'h20, 1, 0, 32'hFFFF_FFFF, 2, 32'h18);
        idle(3, 32'h18);

        // stalled mispredict, back-to-back mispredict in FLUSH, reset during FLUSH
        step(0, 1, 1, 3'b000, 32'h20, 32'h80, 0, 1, 7, 7, 32'h20);
        step(0, 1, 1, 3'b000, 32'h20, 32'h80, 0, 0, 7, 7, 32'h20);
        step(0, 1, 1, 3'b001, 32'h24, 32'h90, 0, 0, 7, 8, 32'h24);
        step(0, 1, 1, 3'b001, 32'h24, 32'h90, 0, 0, 7, 8, 32'h24);
        idle(2, 32'h24);
        step(0, 1, 1, 3'b101, 32'h28, 32'hA0, 0, 0, 9, 3, 32'h28);
        step(1, 1, 1, 3'b101, 32'h28, 32'hA0, 0, 0, 9, 3, 32'h28);
        idle(3, 32'h28);

        for (int k = 0; k < 3000; k++) begin
            a   = rnd_operand();
            b   = ($urandom_range(0, 3) == 0) ? a : rnd_operand();
            pc  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : (32'($urandom_range(0, 31)) << 2);
            ipc = ($urandom_range(0, 1) == 0) ? pc : (32'($urandom_range(0, 31)) << 2);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 3'($urandom_range(0, 7)), pc, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, a, b, ipc);
        end

        // counter saturation: a long run of correctly predicted taken branches
        for (int k = 0; k < 65540; k++)
            step(0, 1, 1, 3'b000, 32'h60, 32'h400, model_pred(32'h60), 0, 4, 4, 32'h60);
        step(0, 1, 1, 3'b000, 32'hFFFF_FFFC, 32'h500, 1, 0, 4, 5, 32'hFFFF_FFFC);
        idle(4, 32'h0);

        repeat (4) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
